// File: rtl/datapath_ctrl_pkg.sv
// Shared definitions for the datapath sequencer: state encoding, instruction
// field positions, ext-op codes, flag bit positions and small decode helpers.
package datapath_ctrl_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Instruction word field positions
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 8;
    localparam int EXT_HI = 7;
    localparam int EXT_LO = 4;
    localparam int RS_HI  = 3;
    localparam int RS_LO  = 0;

    localparam int INSTR_W = 16;
    localparam int FLAGS_W = 5;
    localparam int CNT_W   = 4;

    // Primary op value that selects the extended ALU op field
    localparam logic [3:0] OP_ALU   = 4'b0000;

    // Extended ALU op codes the controller cares about
    localparam logic [3:0] EXT_ADDC = 4'b0111;
    localparam logic [3:0] EXT_SUBC = 4'b1010;
    localparam logic [3:0] EXT_CMP  = 4'b1011;

    // Flag bit positions within AluFlags / FlagsReg
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;

    // True for the ALU ops that consume the stored carry (ADDC, SUBC)
    function automatic logic is_carry_op(input logic [INSTR_W-1:0] instr);
        return (instr[OP_HI:OP_LO] == OP_ALU) &&
               ((instr[EXT_HI:EXT_LO] == EXT_ADDC) ||
                (instr[EXT_HI:EXT_LO] == EXT_SUBC));
    endfunction

    // True for a compare, which only produces flags
    function automatic logic is_cmp_op(input logic [INSTR_W-1:0] instr);
        return (instr[OP_HI:OP_LO] == OP_ALU) &&
               (instr[EXT_HI:EXT_LO] == EXT_CMP);
    endfunction

endpackage

// File: rtl/datapath_ctrl_dec.sv
// One-hot decoder with enable: drives exactly one output high for the
// selected index while enabled, all zeros otherwise.
module reg_onehot_dec #(
    parameter int SEL_W   = 4,
    parameter int NUM_OUT = 16
) (
    input  logic               i_en,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [NUM_OUT-1:0] o_onehot
);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_OUT; gi++) begin : g_bit
            // Each output bit compares the select against its own index
            assign o_onehot[gi] = i_en && (i_sel == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/datapath_ctrl.sv
// Multi-cycle sequencer for the register-file/ALU datapath.
// Accepts one instruction via valid/ready, holds it on the Opcode bus for
// SETTLE_CYCLES execute cycles, then spends one writeback cycle pulsing a
// one-hot register enable and capturing the ALU flags.
// Optional build macro: CMP_NOWRITE_EN -- when defined, a CMP instruction
// suppresses the register write enable in writeback (flags still captured).
module datapath_ctrl
    import datapath_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_REGS      = 16
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_InstrValid,
    output logic                o_InstrReady,
    input  logic [INSTR_W-1:0]  i_Instr,
    output logic [INSTR_W-1:0]  o_Opcode,
    output logic [NUM_REGS-1:0] o_RegEnable,
    output logic                o_Cin,
    input  logic [FLAGS_W-1:0]  i_AluFlags,
    output logic [FLAGS_W-1:0]  o_FlagsReg,
    output logic                o_Busy,
    output logic                o_Done
);

    // Reject illegal configurations at elaboration time
    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("datapath_ctrl: SETTLE_CYCLES must be in 1..15");
        end
        if (NUM_REGS != 16) begin : g_bad_regs
            $error("datapath_ctrl: NUM_REGS is fixed at 16");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [CNT_W-1:0]     r_count;
    logic [INSTR_W-1:0]   r_opcode;
    logic [FLAGS_W-1:0]   r_flags;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_ready;
    logic                 w_accept;
    logic                 w_busy_next;
    logic                 w_done_next;
    logic                 w_wb_en;
    logic                 w_cin;

    // State register
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> EXEC on accept, EXEC -> WB when the settle
    // counter has run out, WB always returns to IDLE after one cycle
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (r_count == '0) begin
                    w_state_next = ST_WB;
                end
            end
            ST_WB: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode: handshake, next values of the registered status flags,
    // writeback enable and the carry-in select
    always_comb begin
        w_ready     = (r_state == ST_IDLE) && !i_Reset;
        w_accept    = w_ready && i_InstrValid;
        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (w_state_next == ST_WB);
`ifdef CMP_NOWRITE_EN
        w_wb_en     = (r_state == ST_WB) && !is_cmp_op(r_opcode);
`else
        w_wb_en     = (r_state == ST_WB);
`endif
        // Carry comes only from the architectural register, never from the
        // live ALU flags, so there is no combinational loop through the ALU
        w_cin       = is_carry_op(r_opcode) && r_flags[FLAG_C];
    end

    // Datapath registers: settle counter, held instruction, flags, status
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            r_count  <= '0;
            r_opcode <= '0;
            r_flags  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_done <= w_done_next;
            if (w_accept) begin
                r_count  <= CNT_LOAD;
                r_opcode <= i_Instr;
            end else if (r_state == ST_EXEC) begin
                if (r_count != '0) begin
                    r_count <= r_count - 1'b1;
                end
            end else if (r_state == ST_WB) begin
                r_opcode <= '0;
                r_flags  <= i_AluFlags;
            end
        end
    end

    // Register write enable decoded from the held destination field
    reg_onehot_dec #(
        .SEL_W   (4),
        .NUM_OUT (NUM_REGS)
    ) u_reg_dec (
        .i_en     (w_wb_en),
        .i_sel    (r_opcode[RD_HI:RD_LO]),
        .o_onehot (o_RegEnable)
    );

    assign o_InstrReady = w_ready;
    assign o_Opcode     = r_opcode;
    assign o_Cin        = w_cin;
    assign o_FlagsReg   = r_flags;
    assign o_Busy       = r_busy;
    assign o_Done       = r_done;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Self-checking bench for datapath_ctrl: two instances (SETTLE_CYCLES=1 and 4),
// table-driven transactions with a writeback scoreboard, plus hand-written
// reset-in-flight and continuous-valid handshake sequences.
// Honours CMP_NOWRITE_EN for the expected CMP write enable.
module tb_datapath_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        valid1, valid4;
    logic [15:0] instr;
    logic [4:0]  alu;

    logic        ready1, cin1, busy1, done1;
    logic [15:0] opcode1, regen1;
    logic [4:0]  flags1;
    logic        ready4, cin4, busy4, done4;
    logic [15:0] opcode4, regen4;
    logic [4:0]  flags4;

    datapath_ctrl #(.SETTLE_CYCLES(1), .NUM_REGS(16)) dut1 (
        .i_Clk(clk), .i_Reset(rst), .i_InstrValid(valid1), .o_InstrReady(ready1),
        .i_Instr(instr), .o_Opcode(opcode1), .o_RegEnable(regen1), .o_Cin(cin1),
        .i_AluFlags(alu), .o_FlagsReg(flags1), .o_Busy(busy1), .o_Done(done1)
    );

    datapath_ctrl #(.SETTLE_CYCLES(4), .NUM_REGS(16)) dut4 (
        .i_Clk(clk), .i_Reset(rst), .i_InstrValid(valid4), .o_InstrReady(ready4),
        .i_Instr(instr), .o_Opcode(opcode4), .o_RegEnable(regen4), .o_Cin(cin4),
        .i_AluFlags(alu), .o_FlagsReg(flags4), .o_Busy(busy4), .o_Done(done4)
    );

    // Observation mux so one transaction task serves both instances
    int          sel;
    logic        m_ready, m_cin, m_busy, m_done;
    logic [15:0] m_opcode, m_regen;
    logic [4:0]  m_flags;
    always_comb begin
        m_ready  = (sel != 0) ? ready4  : ready1;
        m_cin    = (sel != 0) ? cin4    : cin1;
        m_busy   = (sel != 0) ? busy4   : busy1;
        m_done   = (sel != 0) ? done4   : done1;
        m_opcode = (sel != 0) ? opcode4 : opcode1;
        m_regen  = (sel != 0) ? regen4  : regen1;
        m_flags  = (sel != 0) ? flags4  : flags1;
    end

`ifdef CMP_NOWRITE_EN
    localparam logic [15:0] CMP_REGEN = 16'h0000;
`else
    localparam logic [15:0] CMP_REGEN = 16'h0020;
`endif

    typedef struct {
        logic [15:0] regen;
        logic [4:0]  flags;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [15:0] instr;
        logic [4:0]  alu;
        logic [15:0] regen;
        logic        cin;
        logic [4:0]  flags;
    } vec_t;
    vec_t vecs[8];
    vec_t v_s4;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // One full transaction on the selected instance, starting at a negedge
    task automatic run_txn(input int s, input int settle, input vec_t v, input int idx);
        int  n;
        bit  seen;
        sb_t e;
        sel = s;
        n = 0;
        while (!m_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_idle", 32'(m_ready), 1);
        instr = v.instr;
        alu   = v.alu;
        if (s != 0) valid4 = 1'b1; else valid1 = 1'b1;
        sb_q.push_back('{regen: v.regen, flags: v.flags});
        @(negedge clk);
        valid1 = 1'b0;
        valid4 = 1'b0;
        seen = 1'b0;
        e = '{regen: 16'h0, flags: 5'h0};
        for (n = 1; n <= 20 && !seen; n++) begin
            check("cin", 32'(m_cin), 32'(v.cin));
            check("opcode_held", 32'(m_opcode), 32'(v.instr));
            check("busy", 32'(m_busy), 1);
            check("ready_busy", 32'(m_ready), 0);
            if (m_done) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                check("wb_regen", 32'(m_regen), 32'(e.regen));
                check("wb_latency", n, settle + 1);
            end else begin
                check("exec_regen", 32'(m_regen), 0);
            end
            @(negedge clk);
        end
        if (!seen) begin
            fail_now("done_timeout");
            if (sb_q.size() != 0) void'(sb_q.pop_front());
        end else begin
            check("flags_after", 32'(m_flags), 32'(e.flags));
        end
        check("done_pulse_end", 32'(m_done), 0);
        check("regen_after", 32'(m_regen), 0);
        check("opcode_cleared", 32'(m_opcode), 0);
        check("ready_after", 32'(m_ready), 1);
        check("busy_after", 32'(m_busy), 0);
        $display("txn %0d dut=%0d instr=%04h regen=%04h flags=%05b", idx, (s != 0) ? 4 : 1,
                 v.instr, e.regen, m_flags);
    endtask

    initial begin
        int cyc, last_acc, n_acc;

        vecs[0] = '{instr: 16'h0352, alu: 5'b00001, regen: 16'h0008, cin: 1'b0, flags: 5'b00001};
        vecs[1] = '{instr: 16'h0472, alu: 5'b10001, regen: 16'h0010, cin: 1'b1, flags: 5'b10001};
        vecs[2] = '{instr: 16'h0452, alu: 5'b00001, regen: 16'h0010, cin: 1'b0, flags: 5'b00001};
        vecs[3] = '{instr: 16'h04A2, alu: 5'b01000, regen: 16'h0010, cin: 1'b1, flags: 5'b01000};
        vecs[4] = '{instr: 16'h0472, alu: 5'b00110, regen: 16'h0010, cin: 1'b0, flags: 5'b00110};
        vecs[5] = '{instr: 16'h05B6, alu: 5'b11111, regen: CMP_REGEN, cin: 1'b0, flags: 5'b11111};
        vecs[6] = '{instr: 16'h1072, alu: 5'b00000, regen: 16'h0001, cin: 1'b0, flags: 5'b00000};
        vecs[7] = '{instr: 16'hA9C3, alu: 5'b00010, regen: 16'h0200, cin: 1'b0, flags: 5'b00010};
        v_s4    = '{instr: 16'h0F52, alu: 5'b10101, regen: 16'h8000, cin: 1'b0, flags: 5'b10101};

        rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0; instr = '0; alu = '0; sel = 0;
        repeat (2) @(negedge clk);
        check("rst_ready1", 32'(ready1), 0);
        check("rst_ready4", 32'(ready4), 0);
        check("rst_opcode", 32'(opcode1), 0);
        check("rst_regen", 32'(regen1), 0);
        check("rst_cin", 32'(cin1), 0);
        check("rst_flags", 32'(flags1), 0);
        check("rst_busy", 32'(busy1), 0);
        check("rst_done", 32'(done1), 0);
        rst = 1'b0;
        #1;
        check("ready_post_rst", 32'(ready1), 1);
        @(negedge clk);

        // Table-driven transactions on the SETTLE_CYCLES=1 instance
        for (int i = 0; i < 8; i++) begin
            run_txn(0, 1, vecs[i], i);
        end

        // SETTLE_CYCLES=4 with the R15 boundary
        run_txn(1, 4, v_s4, 8);

        // Reset during EXEC: instruction abandoned, no writeback, flags cleared
        sel = 1;
        instr = 16'h0152; alu = 5'b11111; valid4 = 1'b1;
        @(negedge clk);
        valid4 = 1'b0;
        check("rm_busy", 32'(busy4), 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rm_ready", 32'(ready4), 0);
        check("rm_opcode", 32'(opcode4), 0);
        check("rm_regen", 32'(regen4), 0);
        check("rm_cin", 32'(cin4), 0);
        check("rm_flags", 32'(flags4), 0);
        check("rm_busy_clr", 32'(busy4), 0);
        check("rm_done", 32'(done4), 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rm_hold_regen", 32'(regen4), 0);
            check("rm_hold_ready", 32'(ready4), 0);
        end
        rst = 1'b0;
        #1;
        check("rm_ready_rel", 32'(ready4), 1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rm_no_regen", 32'(regen4), 0);
            check("rm_no_done", 32'(done4), 0);
        end
        $display("txn 9 dut=4 instr=0152 abandoned by reset flags=%05b", flags4);

        // Continuous valid on the SETTLE_CYCLES=1 instance
        instr = 16'h0352; alu = 5'b00000;
        last_acc = -1; n_acc = 0;
        valid1 = 1'b1;
        for (cyc = 0; cyc < 18; cyc++) begin
            check("hs_ready_vs_busy", 32'(ready1), 32'(!busy1));
            if (done1) begin
                if (sb_q.size() == 0) begin
                    fail_now("hs_unexpected_done");
                end else begin
                    sb_t e;
                    e = sb_q.pop_front();
                    check("hs_regen", 32'(regen1), 32'(e.regen));
                end
            end
            if (ready1) begin
                if (last_acc >= 0) check("hs_period", cyc - last_acc, 3);
                last_acc = cyc;
                n_acc++;
                sb_q.push_back('{regen: 16'h0008, flags: 5'b00000});
                $display("txn hs accept at cycle %0d instr=0352", cyc);
            end
            @(negedge clk);
        end
        valid1 = 1'b0;
        for (int k = 0; k < 10 && sb_q.size() != 0; k++) begin
            if (done1) begin
                sb_t e;
                e = sb_q.pop_front();
                check("hs_drain_regen", 32'(regen1), 32'(e.regen));
            end
            @(negedge clk);
        end
        check("hs_queue_empty", sb_q.size(), 0);
        check("hs_accepts", n_acc, 6);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
